// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch front end: fetches words over req/ack, splits fields and immediate,
// presents them to decode with valid/ready, and squashes wrong-path fetches on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  input  logic        decReady,
  output logic        instValid,
  output logic [31:0] instPc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  regWriteNum,
  output logic [4:0]  regNum0,
  output logic [4:0]  regNum1,
  output logic [31:0] imm,
  output logic        illegal
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic        r_req, w_req_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_inst, r_inst_pc, r_imm;
  logic        r_illegal;
  logic        w_capture;
  logic [31:0] w_redir_pc;

  function automatic logic [31:0] f_imm(input logic [31:0] inst);
    logic [31:0] v;
    v = 32'h0;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: v = {{20{inst[31]}}, inst[31:20]};
      7'b0100011: v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'b1100011: v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b0110111, 7'b0010111: v = {inst[31:12], 12'b0};
      7'b1101111: v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic f_illegal(input logic [31:0] inst);
    logic ok;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
      7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return !ok || (inst[1:0] != 2'b11);
  endfunction

  assign w_redir_pc = {redirectPc[31:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      StIdle: begin
        w_state_nxt = StFetch;
        if (redirectValid) w_pc_nxt = w_redir_pc;
      end
      StFetch: begin
        if (redirectValid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imemAck ? StFetch : StDrain;
        end else if (imemAck) begin
          w_capture   = 1'b1;
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        if (redirectValid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = StFetch;
        end else if (decReady) begin
          w_state_nxt = StFetch;
        end
      end
      StDrain: begin
        if (redirectValid) w_pc_nxt = w_redir_pc;
        // The in-flight request completes on ack; its data is always discarded.
        if (imemAck) w_state_nxt = StFetch;
      end
      default: w_state_nxt = StIdle;
    endcase
    w_req_nxt   = (w_state_nxt == StFetch) || (w_state_nxt == StDrain);
    w_addr_nxt  = (w_state_nxt == StFetch) ? w_pc_nxt : r_addr;
    w_valid_nxt = (w_state_nxt == StHold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_inst    <= 32'h0;
      r_inst_pc <= 32'h0;
      r_imm     <= 32'h0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
      r_valid <= w_valid_nxt;
      if (w_capture) begin
        r_inst    <= imemData;
        r_inst_pc <= r_pc;
        r_imm     <= f_imm(imemData);
        r_illegal <= f_illegal(imemData);
      end
    end
  end

  assign imemReq     = r_req;
  assign imemAddr    = r_addr;
  assign instValid   = r_valid;
  assign instPc      = r_inst_pc;
  assign opcode      = r_inst[6:0];
  assign func3       = r_inst[14:12];
  assign func7       = r_inst[31:25];
  assign regWriteNum = r_inst[11:7];
  assign regNum0     = r_inst[19:15];
  assign regNum1     = r_inst[24:20];
  assign imm         = r_imm;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed vectors checked with immediate assertions.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        decReady;
  logic        instValid;
  logic [31:0] instPc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  regWriteNum;
  logic [4:0]  regNum0;
  logic [4:0]  regNum1;
  logic [31:0] imm;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .redirectValid(redirectValid),
    .redirectPc   (redirectPc),
    .decReady     (decReady),
    .instValid    (instValid),
    .instPc       (instPc),
    .opcode       (opcode),
    .func3        (func3),
    .func7        (func7),
    .regWriteNum  (regWriteNum),
    .regNum0      (regNum0),
    .regNum1      (regNum1),
    .imm          (imm),
    .illegal      (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then updated and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imemAck = 1'b0; imemData = 32'h0;
    redirectValid = 1'b0; redirectPc = 32'h0; decReady = 1'b0;
    #3;
    chk("rst_req", {31'b0, imemReq}, 32'd0);
    chk("rst_addr", imemAddr, 32'h0);
    chk("rst_valid", {31'b0, instValid}, 32'd0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_pc", instPc, 32'h0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    step();
    rst = 1'b0;

    // 1: addi x1,x0,5 acked two cycles after the request appears
    step();
    chk("t1_req", {31'b0, imemReq}, 32'd1);
    chk("t1_addr", imemAddr, 32'h0);
    step();
    imemAck = 1'b1; imemData = 32'h00500093;
    step();
    imemAck = 1'b0;
    chk("t1_valid", {31'b0, instValid}, 32'd1);
    chk("t1_opcode", {25'b0, opcode}, 32'h13);
    chk("t1_rd", {27'b0, regWriteNum}, 32'd1);
    chk("t1_f3", {29'b0, func3}, 32'd0);
    chk("t1_rs1", {27'b0, regNum0}, 32'd0);
    chk("t1_imm", imm, 32'd5);
    chk("t1_instpc", instPc, 32'h0);
    chk("t1_hold_req", {31'b0, imemReq}, 32'd0);
    decReady = 1'b1;
    step();
    decReady = 1'b0;
    chk("t1_next_addr", imemAddr, 32'h4);
    chk("t1_next_req", {31'b0, imemReq}, 32'd1);
    chk("t1_valid_clr", {31'b0, instValid}, 32'd0);

    // 2: B-type then U-type
    imemAck = 1'b1; imemData = 32'hFE0008E3;
    step();
    imemAck = 1'b0;
    chk("t2b_opcode", {25'b0, opcode}, 32'h63);
    chk("t2b_imm", imm, 32'hFFFFFFF0);
    chk("t2b_instpc", instPc, 32'h4);
    decReady = 1'b1;
    step();
    decReady = 1'b0;
    chk("t2_addr8", imemAddr, 32'h8);
    imemAck = 1'b1; imemData = 32'h123450B7;
    step();
    imemAck = 1'b0;
    chk("t2u_imm", imm, 32'h12345000);
    chk("t2u_rd", {27'b0, regWriteNum}, 32'd1);
    chk("t2u_illegal", {31'b0, illegal}, 32'd0);
    chk("t2u_instpc", instPc, 32'h8);

    // 3: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_valid", {31'b0, instValid}, 32'd1);
      chk("t3_imm", imm, 32'h12345000);
      chk("t3_instpc", instPc, 32'h8);
      chk("t3_opcode", {25'b0, opcode}, 32'h37);
      chk("t3_req", {31'b0, imemReq}, 32'd0);
    end
    decReady = 1'b1;
    step();
    decReady = 1'b0;
    chk("t3_next_addr", imemAddr, 32'hC);

    // 4: redirect before ack drains the old request
    redirectValid = 1'b1; redirectPc = 32'h103;
    step();
    redirectValid = 1'b0;
    chk("t4_drain_req", {31'b0, imemReq}, 32'd1);
    chk("t4_drain_addr", imemAddr, 32'hC);
    step();
    chk("t4_drain_addr2", imemAddr, 32'hC);
    chk("t4_drain_valid", {31'b0, instValid}, 32'd0);
    imemAck = 1'b1; imemData = 32'h00000013;
    step();
    imemAck = 1'b0;
    chk("t4_valid_after", {31'b0, instValid}, 32'd0);
    chk("t4_new_addr", imemAddr, 32'h100);
    chk("t4_new_req", {31'b0, imemReq}, 32'd1);

    // 5: redirect with ack drops the word; then an all-ones word is illegal
    imemAck = 1'b1; imemData = 32'hFFFFFFFF;
    redirectValid = 1'b1; redirectPc = 32'h200;
    step();
    redirectValid = 1'b0; imemAck = 1'b0;
    chk("t5_drop_valid", {31'b0, instValid}, 32'd0);
    chk("t5_drop_addr", imemAddr, 32'h200);
    imemAck = 1'b1;
    step();
    imemAck = 1'b0;
    chk("t5_valid", {31'b0, instValid}, 32'd1);
    chk("t5_illegal", {31'b0, illegal}, 32'd1);
    chk("t5_imm", imm, 32'h0);
    chk("t5_instpc", instPc, 32'h200);
    decReady = 1'b1;
    step();
    decReady = 1'b0;
    chk("t5_next_addr", imemAddr, 32'h204);

    // 6: wrap-around redirect, J/S decode, reset during HOLD
    redirectValid = 1'b1; redirectPc = 32'hFFFFFFFE;
    step();
    redirectValid = 1'b0;
    chk("t6_drain_addr", imemAddr, 32'h204);
    imemAck = 1'b1; imemData = 32'h0;
    step();
    imemAck = 1'b0;
    chk("t6_target_addr", imemAddr, 32'hFFFFFFFC);
    imemAck = 1'b1; imemData = 32'h0080006F;
    step();
    imemAck = 1'b0;
    chk("t6j_imm", imm, 32'h8);
    chk("t6j_opcode", {25'b0, opcode}, 32'h6F);
    chk("t6j_instpc", instPc, 32'hFFFFFFFC);
    decReady = 1'b1;
    step();
    decReady = 1'b0;
    chk("t6_wrap_addr", imemAddr, 32'h0);
    imemAck = 1'b1; imemData = 32'h00112223;
    step();
    imemAck = 1'b0;
    chk("t6s_imm", imm, 32'h4);
    chk("t6s_rs1", {27'b0, regNum0}, 32'd2);
    chk("t6s_rs2", {27'b0, regNum1}, 32'd1);
    chk("t6s_valid", {31'b0, instValid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, instValid}, 32'd0);
    chk("t6_rst_req", {31'b0, imemReq}, 32'd0);
    chk("t6_rst_imm", imm, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("t6_restart_req", {31'b0, imemReq}, 32'd1);
    chk("t6_restart_addr", imemAddr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
